mouse_init_sequencer: RTL and testbench

Master controller for the PS/2 mouse path. It drives the byte transmitter and the byte receiver. After reset it runs the mouse initialisation handshake: reset command, ACK, self-test pass, device ID, enable streaming, ACK. It then reassembles 3-byte movement packets into status/X/Y registers with a one-cycle interrupt strobe toward the bus interface.

---
 rtl/mouse_init_sequencer_pkg.sv | 57 +++++
 rtl/mouse_init_sequencer_if.sv | 21 ++
 rtl/mouse_init_sequencer_watchdog.sv | 25 ++
 rtl/mouse_init_sequencer.sv | 171 +++++++++++++++++
 tb/tb_mouse_init_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/mouse_init_sequencer_pkg.sv
// Shared state encoding, PS/2 command/response bytes and state-class helpers
// for the mouse initialisation sequencer.
package mouse_pkg;

    typedef enum logic [3:0] {
        TX_RST        = 4'd0,
        WAIT_SENT_RST = 4'd1,
        WAIT_ACK_RST  = 4'd2,
        WAIT_BAT      = 4'd3,
        WAIT_ID       = 4'd4,
        TX_EN         = 4'd5,
        WAIT_SENT_EN  = 4'd6,
        WAIT_ACK_EN   = 4'd7,
        PKT_S         = 4'd8,
        PKT_X         = 4'd9,
        PKT_Y         = 4'd10,
        IRQ           = 4'd11
    } master_state_t;

    localparam logic [7:0] CMD_RESET       = 8'hFF;
    localparam logic [7:0] CMD_STREAM_EN   = 8'hF4;
    localparam logic [7:0] RSP_ACK         = 8'hFA;
    localparam logic [7:0] RSP_BAT_OK      = 8'hAA;
    localparam logic [7:0] RSP_DEV_ID      = 8'h00;
    localparam int         STATUS_SYNC_BIT = 3;

    function automatic logic is_command(master_state_t s);
        return s inside {TX_RST, TX_EN};
    endfunction

    function automatic logic is_response(master_state_t s);
        return s inside {WAIT_ACK_RST, WAIT_BAT, WAIT_ID, WAIT_ACK_EN};
    endfunction

    function automatic logic is_streaming(master_state_t s);
        return s inside {PKT_S, PKT_X, PKT_Y, IRQ};
    endfunction

    // States in which the optional watchdog is allowed to run.
    function automatic logic is_timed(master_state_t s);
        return s inside {WAIT_SENT_RST, WAIT_ACK_RST, WAIT_BAT, WAIT_ID,
                         WAIT_SENT_EN, WAIT_ACK_EN, PKT_X, PKT_Y};
    endfunction

    function automatic logic [7:0] command_byte(master_state_t s);
        return (s == TX_EN) ? CMD_STREAM_EN : CMD_RESET;
    endfunction

    function automatic logic [7:0] expected_response(master_state_t s);
        case (s)
            WAIT_BAT: return RSP_BAT_OK;
            WAIT_ID:  return RSP_DEV_ID;
            default:  return RSP_ACK;
        endcase
    endfunction

endpackage

// File: rtl/mouse_init_sequencer_if.sv
// Byte-level link between the sequencer (master) and the PS/2 byte
// transmitter/receiver pair (slave).
interface mouse_init_sequencer_if;
    logic       SEND_BYTE;
    logic [7:0] BYTE_TO_SEND;
    logic       BYTE_SENT;
    logic       READ_ENABLE;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    modport master (
        output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );

    modport slave (
        input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
        output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
    );
endinterface

// File: rtl/mouse_init_sequencer_watchdog.sv
// Per-state watchdog: counts enabled cycles since the last state change and
// flags expiry on the LIMIT-th cycle. Only built with MOUSE_TIMEOUT_EN.
module mouse_watchdog #(
    parameter int LIMIT = 50_000_000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge CLK) begin
        if (RESET || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = enable && (count == CW'(LIMIT - 1));
endmodule

// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse master: runs the reset/BAT/ID/stream-enable handshake, then
// reassembles 3-byte movement packets. Optional watchdog: MOUSE_TIMEOUT_EN.
module mouse_init_sequencer
    import mouse_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                          CLK,
    input  logic                          RESET,
    mouse_init_sequencer_if.master        link,
    output logic [7:0]                    MOUSE_STATUS,
    output logic [7:0]                    MOUSE_DX,
    output logic [7:0]                    MOUSE_DY,
    output logic                          SEND_INTERRUPT,
    output logic                          INIT_DONE,
    output logic [3:0]                    MASTER_STATE
);

    master_state_t state, next_state;

    logic       send_byte;
    logic [7:0] byte_to_send;
    logic       read_enable;
    logic       init_done;
    logic       send_interrupt;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [1:0] rx_error;

    logic [7:0] shadow_status;
    logic [7:0] shadow_dx;

    logic       rsp_ok;
    logic       timeout;

    // Receiver outputs are registered once; the FSM acts one edge later.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rx_valid <= 1'b0;
            rx_byte  <= '0;
            rx_error <= '0;
        end else begin
            rx_valid <= link.BYTE_READY;
            rx_byte  <= link.BYTE_READ;
            rx_error <= link.BYTE_ERROR_CODE;
        end
    end

`ifdef MOUSE_TIMEOUT_EN
    mouse_watchdog #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_watchdog (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (next_state != state),
        .enable  (is_timed(state)),
        .expired (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        next_state = state;
        rsp_ok     = (rx_error == 2'b00) && (rx_byte == expected_response(state));

        unique case (state)
            // A command state issues its byte on entry, so it leaves once
            // SEND_BYTE is up; straight after reset it first raises it.
            TX_RST: if (send_byte) next_state = WAIT_SENT_RST;
            TX_EN:  if (send_byte) next_state = WAIT_SENT_EN;

            WAIT_SENT_RST: begin
                if (link.BYTE_SENT) next_state = WAIT_ACK_RST;
                else if (timeout)   next_state = TX_RST;
            end
            WAIT_SENT_EN: begin
                if (link.BYTE_SENT) next_state = WAIT_ACK_EN;
                else if (timeout)   next_state = TX_RST;
            end

            WAIT_ACK_RST: begin
                if (rx_valid)     next_state = rsp_ok ? WAIT_BAT : TX_RST;
                else if (timeout) next_state = TX_RST;
            end
            WAIT_BAT: begin
                if (rx_valid)     next_state = rsp_ok ? WAIT_ID : TX_RST;
                else if (timeout) next_state = TX_RST;
            end
            WAIT_ID: begin
                if (rx_valid)     next_state = rsp_ok ? TX_EN : TX_RST;
                else if (timeout) next_state = TX_RST;
            end
            WAIT_ACK_EN: begin
                if (rx_valid)     next_state = rsp_ok ? PKT_S : TX_RST;
                else if (timeout) next_state = TX_RST;
            end

            // Only a clean byte with the sync bit set can open a packet.
            PKT_S: begin
                if (rx_valid && (rx_error == 2'b00) && rx_byte[STATUS_SYNC_BIT])
                    next_state = PKT_X;
            end
            PKT_X: begin
                if (rx_valid)     next_state = (rx_error == 2'b00) ? PKT_Y : PKT_S;
                else if (timeout) next_state = PKT_S;
            end
            PKT_Y: begin
                if (rx_valid)     next_state = (rx_error == 2'b00) ? IRQ : PKT_S;
                else if (timeout) next_state = PKT_S;
            end
            IRQ: next_state = PKT_S;

            default: next_state = TX_RST;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state
    // they belong to.
    // NOTE: shadow and output registers are reset explicitly; a reset must
    // never let a half-assembled packet reach the host.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= TX_RST;
            send_byte      <= 1'b0;
            byte_to_send   <= '0;
            read_enable    <= 1'b0;
            init_done      <= 1'b0;
            send_interrupt <= 1'b0;
            shadow_status  <= '0;
            shadow_dx      <= '0;
            MOUSE_STATUS   <= '0;
            MOUSE_DX       <= '0;
            MOUSE_DY       <= '0;
        end else begin
            state          <= next_state;
            send_byte      <= is_command(next_state);
            read_enable    <= is_response(next_state) || is_streaming(next_state);
            init_done      <= is_streaming(next_state);
            send_interrupt <= (next_state == IRQ);

            if (is_command(next_state))
                byte_to_send <= command_byte(next_state);

            if (state == PKT_S && next_state == PKT_X) shadow_status <= rx_byte;
            if (state == PKT_X && next_state == PKT_Y) shadow_dx     <= rx_byte;

            // DY goes straight to the output on the same edge as the others.
            if (next_state == IRQ) begin
                MOUSE_STATUS <= shadow_status;
                MOUSE_DX     <= shadow_dx;
                MOUSE_DY     <= rx_byte;
            end
        end
    end

    assign link.SEND_BYTE    = send_byte;
    assign link.BYTE_TO_SEND = byte_to_send;
    assign link.READ_ENABLE  = read_enable;
    assign INIT_DONE         = init_done;
    assign SEND_INTERRUPT    = send_interrupt;
    assign MASTER_STATE      = state;

endmodule

// File: tb/tb_mouse_init_sequencer.sv
// Directed bench for mouse_init_sequencer: init handshake, retry, packet
// assembly, sync/error handling, mid-stream reset and optional watchdog.
`timescale 1ns/1ps
module tb_mouse_init_sequencer;
    import mouse_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] MOUSE_STATUS, MOUSE_DX, MOUSE_DY;
    logic       SEND_INTERRUPT, INIT_DONE;
    logic [3:0] MASTER_STATE;

    int checks    = 0;
    int failures  = 0;
    int irq_count = 0;
    int irq_base  = 0;
    int waited    = 0;

    mouse_init_sequencer_if link ();

    mouse_init_sequencer #(
        .TIMEOUT_CYCLES (100)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .link           (link),
        .MOUSE_STATUS   (MOUSE_STATUS),
        .MOUSE_DX       (MOUSE_DX),
        .MOUSE_DY       (MOUSE_DY),
        .SEND_INTERRUPT (SEND_INTERRUPT),
        .INIT_DONE      (INIT_DONE),
        .MASTER_STATE   (MASTER_STATE)
    );

    always #10 CLK = ~CLK;

    always @(posedge CLK) if (SEND_INTERRUPT === 1'b1) irq_count++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pulse_sent();
        link.BYTE_SENT = 1'b1;
        tick();
        link.BYTE_SENT = 1'b0;
    endtask

    // One-cycle receiver pulse; returns after the edge that moves the state.
    task automatic rx(input logic [7:0] b, input logic [1:0] err);
        link.BYTE_READ       = b;
        link.BYTE_ERROR_CODE = err;
        link.BYTE_READY      = 1'b1;
        tick();
        link.BYTE_READY      = 1'b0;
        link.BYTE_ERROR_CODE = 2'b00;
        tick();
    endtask

    // Clean handshake, starting in the TX_RST cycle that carries SEND_BYTE.
    task automatic do_init();
        check("init_ff_req",    link.SEND_BYTE, 1);
        check("init_ff_byte",   link.BYTE_TO_SEND, 8'hFF);
        tick();
        check("init_ff_single", link.SEND_BYTE, 0);
        pulse_sent();
        check("init_wait_ack",  MASTER_STATE, WAIT_ACK_RST);
        rx(8'hFA, 2'b00);
        rx(8'hAA, 2'b00);
        check("init_wait_id",   MASTER_STATE, WAIT_ID);
        rx(8'h00, 2'b00);
        check("init_f4_req",    link.SEND_BYTE, 1);
        check("init_f4_byte",   link.BYTE_TO_SEND, 8'hF4);
        check("init_tx_en",     MASTER_STATE, TX_EN);
        tick();
        check("init_f4_single", link.SEND_BYTE, 0);
        check("init_f4_held",   link.BYTE_TO_SEND, 8'hF4);
        pulse_sent();
        check("init_ack_en",    MASTER_STATE, WAIT_ACK_EN);
        check("init_not_done",  INIT_DONE, 0);
        rx(8'hFA, 2'b00);
        check("init_pkt_s",     MASTER_STATE, PKT_S);
        check("init_done",      INIT_DONE, 1);
    endtask

    initial begin
        RESET                = 1'b1;
        link.BYTE_SENT       = 1'b0;
        link.BYTE_READY      = 1'b0;
        link.BYTE_READ       = 8'h00;
        link.BYTE_ERROR_CODE = 2'b00;
        repeat (3) tick();

        // Reset values
        check("rst_send",    link.SEND_BYTE, 0);
        check("rst_byte",    link.BYTE_TO_SEND, 8'h00);
        check("rst_rd_en",   link.READ_ENABLE, 0);
        check("rst_mouse",   {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h000000);
        check("rst_irq",     SEND_INTERRUPT, 0);
        check("rst_done",    INIT_DONE, 0);
        check("rst_state",   MASTER_STATE, TX_RST);

        // First command in the first cycle after reset release
        RESET = 1'b0;
        tick();
        check("first_send",  link.SEND_BYTE, 1);
        check("first_byte",  link.BYTE_TO_SEND, 8'hFF);
        check("first_state", MASTER_STATE, TX_RST);
        tick();
        check("first_single", link.SEND_BYTE, 0);

        // A received byte during a command state is ignored
        rx(8'hFA, 2'b00);
        check("cmd_ignore_rx", MASTER_STATE, WAIT_SENT_RST);
        check("cmd_rd_en",     link.READ_ENABLE, 0);
        pulse_sent();
        check("ack_state",     MASTER_STATE, WAIT_ACK_RST);
        check("ack_rd_en",     link.READ_ENABLE, 1);

        // Bad BAT forces a retry from the reset command
        rx(8'hFA, 2'b00);
        check("bat_state",     MASTER_STATE, WAIT_BAT);
        rx(8'hFC, 2'b00);
        check("badbat_state",  MASTER_STATE, TX_RST);
        do_init();

        // Packet 08/05/FB with exact interrupt timing
        irq_base = irq_count;
        rx(8'h08, 2'b00);
        check("pkt_x",         MASTER_STATE, PKT_X);
        rx(8'h05, 2'b00);
        check("pkt_y",         MASTER_STATE, PKT_Y);
        link.BYTE_READ  = 8'hFB;
        link.BYTE_READY = 1'b1;
        tick();
        link.BYTE_READY = 1'b0;
        check("pkt_irq_early", SEND_INTERRUPT, 0);
        tick();
        check("pkt_irq",       SEND_INTERRUPT, 1);
        check("pkt_irq_state", MASTER_STATE, IRQ);
        check("pkt_values",    {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h0805FB);
        tick();
        check("pkt_irq_end",   SEND_INTERRUPT, 0);
        check("pkt_back_s",    MASTER_STATE, PKT_S);
        check("pkt_irq_count", irq_count - irq_base, 1);

        // Sync loss, framing/parity errors, then a good packet
        irq_base = irq_count;
        rx(8'h00, 2'b00);
        check("sync_drop",     MASTER_STATE, PKT_S);
        rx(8'h08, 2'b10);
        check("sync_err_drop", MASTER_STATE, PKT_S);
        rx(8'h18, 2'b00);
        check("sync_accept",   MASTER_STATE, PKT_X);
        rx(8'h55, 2'b01);
        check("par_discard",   MASTER_STATE, PKT_S);
        check("par_unchanged", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h0805FB);
        rx(8'h18, 2'b00);
        rx(8'h01, 2'b00);
        rx(8'h02, 2'b00);
        check("sync_irq",      SEND_INTERRUPT, 1);
        check("sync_values",   {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h180102);
        tick();
        check("sync_irq_count", irq_count - irq_base, 1);

        // Reset in the middle of a packet
        rx(8'h28, 2'b00);
        check("mid_pkt_x",     MASTER_STATE, PKT_X);
        RESET = 1'b1;
        tick();
        check("mid_rst_state", MASTER_STATE, TX_RST);
        check("mid_rst_mouse", {MOUSE_STATUS, MOUSE_DX, MOUSE_DY}, 24'h000000);
        check("mid_rst_ctl",   {link.SEND_BYTE, link.READ_ENABLE, INIT_DONE, SEND_INTERRUPT}, 4'b0000);
        check("mid_rst_byte",  link.BYTE_TO_SEND, 8'h00);
        RESET = 1'b0;
        tick();
        check("mid_rst_send",  link.SEND_BYTE, 1);
        check("mid_rst_ff",    link.BYTE_TO_SEND, 8'hFF);
        // A stale BYTE_SENT landing in TX_RST must not skip the wait state
        pulse_sent();
        check("stale_sent",    MASTER_STATE, WAIT_SENT_RST);

`ifdef MOUSE_TIMEOUT_EN
        // Watchdog: silent mouse in WAIT_BAT
        pulse_sent();
        rx(8'hFA, 2'b00);
        check("wd_bat_state",  MASTER_STATE, WAIT_BAT);
        waited = 0;
        while (MASTER_STATE !== TX_RST && waited < 300) begin
            tick();
            waited++;
        end
        check("wd_bat_cycles", waited, 100);
        check("wd_bat_send",   link.SEND_BYTE, 1);
        do_init();

        // Watchdog: stalled packet resyncs without interrupt
        irq_base = irq_count;
        rx(8'h08, 2'b00);
        rx(8'h05, 2'b00);
        check("wd_pkt_y",      MASTER_STATE, PKT_Y);
        waited = 0;
        while (MASTER_STATE !== PKT_S && waited < 300) begin
            tick();
            waited++;
        end
        check("wd_pkt_cycles", waited, 100);
        check("wd_pkt_done",   INIT_DONE, 1);
        check("wd_pkt_no_irq", irq_count - irq_base, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
